// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit that owns the HI/LO registers.
// Multiply: radix-2 Booth, 32 iterations. Divide: restoring division on
// operand magnitudes, 32 iterations, with the signs fixed up at the end.
// A start is accepted only in IDLE or DONE. Divide-by-zero skips straight
// to DONE with w_divZero set and leaves HI/LO untouched.
//
// Handshake: flagMultStart/flagDivStart are single-cycle requests. They are
// honoured only when w_busy is low, are never queued, and multiply wins when
// both are asserted together. w_done is a one-cycle pulse. HI/LO are valid
// from that cycle on and hold until the next completing operation.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flagMultStart,
  input  logic        flagDivStart,
  input  logic [31:0] w_opA,
  input  logic [31:0] w_opB,
  output logic [31:0] w_hiOut,
  output logic [31:0] w_loOut,
  output logic        w_busy,
  output logic        w_done,
  output logic        w_divZero,
  output logic [1:0]  w_dbgState
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state;
  logic [5:0]  cnt;

  // Booth accumulator {A, Q, q-1}. A carries one guard bit so that
  // subtracting a most-negative multiplicand cannot overflow.
  logic [65:0] acc;
  logic [32:0] mcand;

  // Restoring divider: partial remainder, dividend/quotient shift register,
  // divisor magnitude and the result sign fix-ups.
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvsr;
  logic        neg_q;
  logic        neg_r;

  logic [65:0] acc_next;
  logic [32:0] a_sum;
  logic [32:0] shifted;
  logic [31:0] diff;
  logic        fits;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] q_res;
  logic [31:0] r_res;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  assign w_dbgState = state;

  // One Booth step: add/sub multiplicand into A, then arithmetic shift right.
  always_comb begin
    a_sum = acc[65:33];
    case (acc[1:0])
      2'b01:   a_sum = acc[65:33] + mcand;
      2'b10:   a_sum = acc[65:33] - mcand;
      default: a_sum = acc[65:33];
    endcase
    acc_next = {a_sum[32], a_sum, acc[32:1]};
  end

  // One restoring-division step plus the final sign correction.
  always_comb begin
    shifted  = {rem, quo[31]};
    fits     = (shifted >= {1'b0, dvsr});
    diff     = shifted[31:0] - dvsr;
    rem_next = fits ? diff : shifted[31:0];
    quo_next = {quo[30:0], fits};
    q_res    = neg_q ? (32'd0 - quo_next) : quo_next;
    r_res    = neg_r ? (32'd0 - rem_next) : rem_next;
    abs_a    = w_opA[31] ? (32'd0 - w_opA) : w_opA;
    abs_b    = w_opB[31] ? (32'd0 - w_opB) : w_opB;
  end

  // Control FSM, datapath registers and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= 6'd0;
      acc       <= 66'd0;
      mcand     <= 33'd0;
      rem       <= 32'd0;
      quo       <= 32'd0;
      dvsr      <= 32'd0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      w_hiOut   <= 32'd0;
      w_loOut   <= 32'd0;
      w_busy    <= 1'b0;
      w_done    <= 1'b0;
      w_divZero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          state     <= ST_IDLE;
          w_busy    <= 1'b0;
          w_done    <= 1'b0;
          w_divZero <= 1'b0;
          if (flagMultStart) begin
            acc    <= {33'd0, w_opB, 1'b0};
            mcand  <= {w_opA[31], w_opA};
            cnt    <= 6'd0;
            state  <= ST_MULT;
            w_busy <= 1'b1;
          end else if (flagDivStart && (w_opB != 32'd0)) begin
            rem    <= 32'd0;
            quo    <= abs_a;
            dvsr   <= abs_b;
            neg_q  <= w_opA[31] ^ w_opB[31];
            neg_r  <= w_opA[31];
            cnt    <= 6'd0;
            state  <= ST_DIV;
            w_busy <= 1'b1;
          end else if (flagDivStart) begin
            state     <= ST_DONE;
            w_done    <= 1'b1;
            w_divZero <= 1'b1;
          end
        end
        ST_MULT: begin
          acc <= acc_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            w_hiOut <= acc_next[64:33];
            w_loOut <= acc_next[32:1];
            state   <= ST_DONE;
            w_busy  <= 1'b0;
            w_done  <= 1'b1;
          end
        end
        ST_DIV: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            w_hiOut <= r_res;
            w_loOut <= q_res;
            state   <= ST_DONE;
            w_busy  <= 1'b0;
            w_done  <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          w_busy <= 1'b0;
          w_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random bench for mult_div_unit with an expected-result queue.
module tb_mult_div_unit;

  logic        clk;
  logic        reset_n;
  logic        flagMultStart;
  logic        flagDivStart;
  logic [31:0] w_opA;
  logic [31:0] w_opB;
  logic [31:0] w_hiOut;
  logic [31:0] w_loOut;
  logic        w_busy;
  logic        w_done;
  logic        w_divZero;
  logic [1:0]  w_dbgState;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // {divZero, hi, lo} expected per operation
  logic [64:0] exp_q[$];

  mult_div_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flagMultStart(flagMultStart),
    .flagDivStart (flagDivStart),
    .w_opA        (w_opA),
    .w_opB        (w_opB),
    .w_hiOut      (w_hiOut),
    .w_loOut      (w_loOut),
    .w_busy       (w_busy),
    .w_done       (w_done),
    .w_divZero    (w_divZero),
    .w_dbgState   (w_dbgState)
  );

  // clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total_cnt);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Drive one operation, wait for done, compare against the queue head.
  // mode 1: change w_opA after 5 cycles and pulse flagDivStart at iteration 10.
  task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi,
                        input logic [31:0] elo, input logic edz, input int mode);
    int          n;
    int          busy_cycles;
    logic [64:0] e;
    exp_q.push_back({edz, ehi, elo});
    w_opA         = a;
    w_opB         = b;
    flagMultStart = m;
    flagDivStart  = d;
    @(posedge clk); #1;
    flagMultStart = 1'b0;
    flagDivStart  = 1'b0;
    n = 0;
    busy_cycles = 0;
    while (w_done !== 1'b1 && n < 100) begin
      if (w_busy === 1'b1) busy_cycles++;
      if (mode == 1) begin
        if (n == 5) w_opA = 32'h0000_0007;
        flagDivStart = (n == 10);
      end
      @(posedge clk); #1;
      n++;
    end
    flagDivStart = 1'b0;
    chk("done_seen", 64'(w_done), 64'd1);
    chk("latency", 64'(n), edz ? 64'd0 : 64'd32);
    chk("busy_cycles", 64'(busy_cycles), edz ? 64'd0 : 64'd32);
    e = exp_q.pop_front();
    chk("hi", 64'(w_hiOut), 64'(e[63:32]));
    chk("lo", 64'(w_loOut), 64'(e[31:0]));
    chk("div_zero", 64'(w_divZero), 64'(e[64]));
    @(posedge clk); #1;
    chk("done_pulse_end", 64'(w_done), 64'd0);
    chk("div_zero_end", 64'(w_divZero), 64'd0);
    chk("busy_idle", 64'(w_busy), 64'd0);
    chk("hi_hold", 64'(w_hiOut), 64'(e[63:32]));
    chk("lo_hold", 64'(w_loOut), 64'(e[31:0]));
  endtask

  initial begin
    logic [31:0]        ra;
    logic [31:0]        rb;
    logic [63:0]        prod;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    int                 done_cnt;

    reset_n       = 1'b0;
    flagMultStart = 1'b0;
    flagDivStart  = 1'b0;
    w_opA         = 32'd0;
    w_opB         = 32'd0;
    #18;
    chk("rst_hi", 64'(w_hiOut), 64'd0);
    chk("rst_lo", 64'(w_loOut), 64'd0);
    chk("rst_busy", 64'(w_busy), 64'd0);
    chk("rst_done", 64'(w_done), 64'd0);
    chk("rst_dz", 64'(w_divZero), 64'd0);
    #4 reset_n = 1'b1;
    @(posedge clk); #1;

    // multiplies
    run_op(1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0);
    run_op(1, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 0);
    run_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0, 0);

    // signed divides
    run_op(0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
    run_op(0, 1, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0);
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 0);

    // divide by zero keeps the preloaded HI/LO
    run_op(1, 0, 32'h0001_2345, 32'h10, 32'h0000_0000, 32'h0012_3450, 0, 0);
    run_op(0, 1, 32'd5, 32'd0, 32'h0000_0000, 32'h0012_3450, 1, 0);

    // simultaneous starts: multiply wins
    run_op(1, 1, 32'd6, 32'd3, 32'd0, 32'd18, 0, 0);

    // operand change and stray divide start mid-multiply: 1000 * -5
    run_op(1, 0, 32'd1000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_EC78, 0, 1);

    // random operations against a behavioural model
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        rb   = $urandom;
        prod = {{32{ra[31]}}, ra} * {{32{rb[31]}}, rb};
        run_op(1, 0, ra, rb, prod[63:32], prod[31:0], 0, 0);
      end else begin
        rb = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 5000));
        if ($urandom_range(0, 1) == 1) rb = 32'd0 - rb;
        if (rb == 32'd0) rb = 32'd3;
        if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd2;
        sa = ra;
        sb = rb;
        sq = sa / sb;
        sr = sa % sb;
        run_op(0, 1, ra, rb, sr, sq, 0, 0);
      end
    end

    // asynchronous reset in the middle of a divide
    w_opA        = 32'h7FFF_FFFF;
    w_opB        = 32'd3;
    flagDivStart = 1'b1;
    @(posedge clk); #1;
    flagDivStart = 1'b0;
    repeat (15) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_hi", 64'(w_hiOut), 64'd0);
    chk("arst_lo", 64'(w_loOut), 64'd0);
    chk("arst_busy", 64'(w_busy), 64'd0);
    chk("arst_done", 64'(w_done), 64'd0);
    chk("arst_dz", 64'(w_divZero), 64'd0);
    #2 reset_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (w_done !== 1'b0) done_cnt++;
    end
    chk("no_done_after_reset", 64'(done_cnt), 64'd0);
    run_op(1, 0, 32'd3, 32'd4, 32'd0, 32'd12, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
